// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the shift-add multiplier sequencer
package mul_pkg;

  // Sequencer states; outputs are decoded from the registered state only.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // Default operand width; the product register is twice this wide.
  localparam int MUL_WIDTH = 32;

  // Index of the final add-shift iteration for a given operand width.
  function automatic int iter_last(input int width);
    return width - 1;
  endfunction

  localparam int ITER_LAST = iter_last(MUL_WIDTH);

endpackage

// File: rtl/mul_addsub.sv
// rtl/mul_addsub.sv - combinational (WIDTH+1)-bit add/subtract for the product upper half
module mul_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  input  logic           i_sub,
  output logic [WIDTH:0] o_sum
);

  // Subtract is a + ~b + 1; with i_sub tied low the inversion and carry-in fold away.
  assign o_sum = i_a + (i_b ^ {(WIDTH + 1){i_sub}}) + {{WIDTH{1'b0}}, i_sub};

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-add multiplier sequencer; MUL_SIGNED_EN selects two's complement operands
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [WIDTH-1:0]     Multiplier_in,
  input  logic [WIDTH-1:0]     Multiplicand_out,
  output logic                 W_ctrl,
  output logic [2*WIDTH-1:0]   Product_out,
  output logic                 Busy,
  output logic                 Ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(iter_last(WIDTH));

  state_e             r_state;
  state_e             w_next;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic               w_last;
  logic               w_ext_hi;
  logic               w_ext_mc;
  logic               w_sub;
  logic [WIDTH:0]     w_a;
  logic [WIDTH:0]     w_b;
  logic [WIDTH:0]     w_sum;

  assign w_last = (r_count == LAST_CNT);

`ifdef MUL_SIGNED_EN
  // Sign-extend both operands; the multiplier's sign bit carries negative weight, so the
  // last iteration subtracts the multiplicand instead of adding it.
  assign w_ext_hi = r_product[2*WIDTH-1];
  assign w_ext_mc = Multiplicand_out[WIDTH-1];
  assign w_sub    = w_last & r_product[0];
`else
  assign w_ext_hi = 1'b0;
  assign w_ext_mc = 1'b0;
  assign w_sub    = 1'b0;
`endif

  assign w_a = {w_ext_hi, r_product[2*WIDTH-1:WIDTH]};
  assign w_b = r_product[0] ? {w_ext_mc, Multiplicand_out} : '0;

  mul_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  assign Product_out = r_product;

  // State, iteration count and product register.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        LOAD: begin
          r_product <= {{WIDTH{1'b0}}, Multiplier_in};
          r_count   <= '0;
        end
        CALC: begin
          // The (WIDTH+1)-bit sum's top bit (carry or sign) enters the MSB as P shifts right.
          r_product <= {w_sum, r_product[WIDTH-1:1]};
          if (!w_last) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    w_next = r_state;
    W_ctrl = 1'b0;
    Busy   = 1'b0;
    Ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (Run) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        W_ctrl = 1'b1;
        Busy   = 1'b1;
        w_next = CALC;
      end
      CALC: begin
        Busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        Ready  = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer with an external Multiplicand register
module tb_mul_sequencer;

  localparam int W = 32;

  logic           clk;
  logic           Reset;
  logic           Run;
  logic [W-1:0]   Multiplier_in;
  logic [W-1:0]   Multiplicand_in;
  logic [W-1:0]   Multiplicand_out;
  logic           W_ctrl;
  logic [2*W-1:0] Product_out;
  logic           Busy;
  logic           Ready;

  int n_checks;
  int n_fail;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk              (clk),
    .Reset            (Reset),
    .Run              (Run),
    .Multiplier_in    (Multiplier_in),
    .Multiplicand_out (Multiplicand_out),
    .W_ctrl           (W_ctrl),
    .Product_out      (Product_out),
    .Busy             (Busy),
    .Ready            (Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External Multiplicand register written by the sequencer's W_ctrl.
  logic [W-1:0] r_mcand = '0;
  always @(posedge clk) if (W_ctrl) r_mcand <= Multiplicand_in;
  assign Multiplicand_out = r_mcand;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ext(input logic [W-1:0] v);
`ifdef MUL_SIGNED_EN
    return {{W{v[W-1]}}, v};
`else
    return {{W{1'b0}}, v};
`endif
  endfunction

  // Product register after k iterations: partial product of the low k multiplier bits,
  // aligned to the top, plus the not-yet-consumed multiplier bits below it.
  function automatic logic [2*W-1:0] partial(input logic [W-1:0] mc, input logic [W-1:0] mp, input int k);
    logic [2*W-1:0] one;
    logic [2*W-1:0] low;
    one = 1;
    low = {{W{1'b0}}, mp} & ((one << k) - one);
    return ((ext(mc) * low) << (W - k)) + ({{W{1'b0}}, mp} >> k);
  endfunction

  // Behavioural model: phase 0 idle, 1 load, 2 calc (m_k iterations done), 3 done.
  int             m_phase = 0;
  int             m_k = 0;
  bit             m_valid = 0;
  logic [W-1:0]   m_mc, m_mp;
  logic [2*W-1:0] m_hold = '0;

  always @(posedge clk) begin
    if (!Reset) begin
      m_valid = 1;
      m_phase = 0;
      m_hold  = '0;
    end else begin
      case (m_phase)
        0: if (Run) m_phase = 1;
        1: begin
          m_mc = Multiplicand_in;
          m_mp = Multiplier_in;
          m_k = 0;
          m_phase = 2;
        end
        2: begin
          m_k++;
          if (m_k == W) begin
            m_phase = 3;
            m_hold = ext(m_mc) * ext(m_mp);
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare DUT against the model on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (m_valid) begin
      check("w_ctrl", {63'd0, W_ctrl}, {63'd0, m_phase == 1});
      check("busy",   {63'd0, Busy},   {63'd0, m_phase == 1 || m_phase == 2});
      check("ready",  {63'd0, Ready},  {63'd0, m_phase == 3});
      check("product", Product_out, (m_phase == 2) ? partial(m_mc, m_mp, m_k) : m_hold);
    end
  end

  // One operation with literal expectations; disturb re-pulses Run in CALC, abort_at resets.
  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [2*W-1:0] exp,
                        input bit disturb, input int abort_at);
    int c;
    bit got;
    @(posedge clk); #2;
    Multiplicand_in = mc;
    Multiplier_in = mp;
    Run = 1'b1;
    @(posedge clk); #2;
    Run = 1'b0;
    c = 0;
    got = 0;
    while (c < 60 && !got) begin
      @(negedge clk);
      c++;
      if (c == 1) check("wctrl_load", {63'd0, W_ctrl}, 64'd1);
      if (c == 2) check("wctrl_calc", {63'd0, W_ctrl}, 64'd0);
      if (disturb && c == 5) begin Run = 1'b1; Multiplier_in = 7; end
      if (disturb && c == 8) Run = 1'b0;
      if (abort_at != 0 && c == abort_at) Reset = 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        Reset = 1'b1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_product", Product_out, 64'd0);
      end
      if (Ready) got = 1;
    end
    if (abort_at != 0) begin
      check("abort_no_ready", {63'd0, got}, 64'd0);
    end else begin
      check("ready_seen", {63'd0, got}, 64'd1);
      check("ready_latency", 64'(c), 64'd34);
      check("result", Product_out, exp);
      @(negedge clk);
      check("ready_single", {63'd0, Ready}, 64'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    Reset = 1'b0;
    Run = 1'b0;
    Multiplier_in = '0;
    Multiplicand_in = '0;
    repeat (2) @(posedge clk);
    #2 Reset = 1'b1;
    @(negedge clk);
    check("rst_product", Product_out, 64'd0);
    check("rst_wctrl", {63'd0, W_ctrl}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_ready", {63'd0, Ready}, 64'd0);

    run_op(32'd125, 32'd3, 64'd375, 0, 0);
    run_op(32'd125, 32'd3, 64'd375, 1, 0);
    run_op(32'd125, 32'd3, 64'd0, 0, 11);
    run_op(32'd125, 32'd3, 64'd375, 0, 0);
`ifdef MUL_SIGNED_EN
    run_op(32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 0, 0);
`else
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 0);
    run_op(32'hFFFFFFFE, 32'd3, 64'h2_FFFFFFFA, 0, 0);
`endif

    // Random traffic: operand corners, Run held or pulsed at any time, occasional resets.
    repeat (3000) begin
      @(posedge clk); #2;
      Run = ($urandom_range(0, 3) == 0);
      Multiplicand_in = ($urandom_range(0, 5) == 0) ? {W{1'b1}} : W'($urandom);
      Multiplier_in = ($urandom_range(0, 5) == 0) ? {W{1'b1}} : W'($urandom);
      Reset = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #2;
    Reset = 1'b1;
    Run = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
